qubit_tally: RTL

- Multi-channel, fully synchronous successor to the single-pair qubit up/down counter.
- Samples per-channel measurement strobes and outcome bits from the MCU header through a synchroniser.
- Tallies |0> and |1> outcomes per channel over a fixed cycle window, snapshots the totals, and hands them to a reader over a valid/ready interface.
- Drives the 4 board LEDs with a live channel-0 balance display.

---
 rtl/qubit_tally.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/qubit_tally.sv
// qubit_tally: multi-channel qubit outcome tally over a fixed cycle window.
// Per-channel strobes/outcomes are synchronised, counted as |0>/|1> during a
// WIN_CYC-cycle window, snapshotted and offered on a valid/ready interface.
// Build option: define QRNG_SAT_EN to make counters saturate instead of wrap.
module qubit_tally #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int WIN_CYC  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       meas_strb,
  input  logic [CHANNELS-1:0]       meas_bit,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [CHANNELS*CNT_W-1:0] rd_cnt0,
  output logic [CHANNELS*CNT_W-1:0] rd_cnt1,
  output logic                      busy,
  output logic                      ovf,
  output logic                      drop,
  output logic [3:0]                led
);

  localparam int WW = $clog2(WIN_CYC);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t                          state;
  logic [CHANNELS-1:0]             strb_s1, strb_s2, strb_s3;
  logic [CHANNELS-1:0]             bit_s1, bit_s2;
  logic [CHANNELS-1:0]             evt;
  logic [WW-1:0]                   win;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt0, cnt1;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt0_nxt, cnt1_nxt;
  logic [CHANNELS-1:0][CNT_W-1:0]  snap0, snap1;
  logic                            ovf_hit;
  logic [CNT_W-1:0]                diff;

  // Two-flop synchronisers on strobe and outcome, third strobe flop for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      strb_s1 <= '0;
      strb_s2 <= '0;
      strb_s3 <= '0;
      bit_s1  <= '0;
      bit_s2  <= '0;
    end else begin
      strb_s1 <= meas_strb;
      strb_s2 <= strb_s1;
      strb_s3 <= strb_s2;
      bit_s1  <= meas_bit;
      bit_s2  <= bit_s1;
    end
  end

  assign evt = strb_s2 & ~strb_s3;

  // Next live counts for this cycle's events, flagging increments from all-ones
  always_comb begin
    cnt0_nxt = cnt0;
    cnt1_nxt = cnt1;
    ovf_hit  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (evt[i]) begin
        if (bit_s2[i]) begin
          if (cnt1[i] == '1) begin
            ovf_hit = 1'b1;
`ifdef QRNG_SAT_EN
            cnt1_nxt[i] = cnt1[i];
`else
            cnt1_nxt[i] = '0;
`endif
          end else begin
            cnt1_nxt[i] = cnt1[i] + CNT_W'(1);
          end
        end else begin
          if (cnt0[i] == '1) begin
            ovf_hit = 1'b1;
`ifdef QRNG_SAT_EN
            cnt0_nxt[i] = cnt0[i];
`else
            cnt0_nxt[i] = '0;
`endif
          end else begin
            cnt0_nxt[i] = cnt0[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Window FSM: counting, snapshot capture, reader handshake and sticky flags
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state    <= IDLE;
      win      <= '0;
      cnt0     <= '0;
      cnt1     <= '0;
      snap0    <= '0;
      snap1    <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      drop     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            win   <= '0;
            cnt0  <= '0;
            cnt1  <= '0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          win  <= win + WW'(1);
          cnt0 <= cnt0_nxt;
          cnt1 <= cnt1_nxt;
          if (ovf_hit) ovf <= 1'b1;
          // snapshot takes the next-state counts so last-cycle events are included
          if (win == WIN_LAST) begin
            snap0    <= cnt0_nxt;
            snap1    <= cnt1_nxt;
            rd_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (|evt) drop <= 1'b1;
          if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            if (start) begin
              win   <= '0;
              cnt0  <= '0;
              cnt1  <= '0;
              busy  <= 1'b1;
              state <= COUNT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_cnt0 = snap0;
  assign rd_cnt1 = snap1;
  assign diff    = cnt1[0] - cnt0[0];
  assign led     = diff[3:0];

endmodule
